i2s_codec_slave: RTL and testbench

//  Codec-side (responder) end of the I2S link driven by the codec_if master:

---
 rtl/i2s_codec_slave.sv | 193 +++++++++++++++++++
 tb/tb_i2s_codec_slave.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/i2s_codec_slave.sv
// i2s_codec_slave: codec-side I2S responder that deserialises sdin into per-channel
// words and serialises host words onto sdout, timed by the master's sclk/lrclk.
//   clk          in   system clock, at least 4x sclk
//   rstn         in   synchronous reset, active-low
//   codec_lrclk  in   word select, 0 = ch0 (left), 1 = ch1 (right)
//   codec_sclk   in   bit clock from the master
//   codec_sdin   in   serial data master -> codec
//   codec_sdout  out  serial data codec -> master
//   rx_vld/rx_chan/rx_data  out  received word strobe, channel, sample
//   rx_err       out  short frame pulse, word dropped
//   tx_vld/tx_data0/tx_data1  in  host samples to send
//   tx_ack/tx_chan  out  word latched strobe and its channel
//   tx_unf       out  underrun pulse, zeros sent
// Build option LOOPBACK_EN: transmit the last word received on the same channel.
`timescale 1ns/1ps
module i2s_codec_slave #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             codec_lrclk,
    input  logic             codec_sclk,
    input  logic             codec_sdin,
    output logic             codec_sdout,
    output logic             rx_vld,
    output logic             rx_chan,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_err,
    input  logic             tx_vld,
    input  logic [WIDTH-1:0] tx_data0,
    input  logic [WIDTH-1:0] tx_data1,
    output logic             tx_ack,
    output logic             tx_chan,
    output logic             tx_unf
);
    localparam int KW = $clog2(WIDTH + 2);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH);
    localparam logic [KW-1:0] K_SAT  = KW'(WIDTH + 1);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_RUN} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
    logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic sclk_s, lr_s, sdin_s, rise, fall, start, tx_ok;
    logic lr_prev_q, lr_prev_d;
    logic [KW-1:0] k_q, k_d, k_inc;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, rx_data_q, rx_data_d;
    logic [WIDTH-1:0] rx_word, tx_src;
    logic sdout_q, sdout_d, rx_vld_q, rx_vld_d, rx_chan_q, rx_chan_d, rx_err_q, rx_err_d;
    logic tx_ack_q, tx_ack_d, tx_chan_q, tx_chan_d, tx_unf_q, tx_unf_d;

    // Oldest stage drops off the top; all three pins share the same latency so
    // lrclk and sdin stay aligned with the detected sclk edges.
    always_comb begin
        sclk_sync_d = SYNC_STAGES'({sclk_sync_q, codec_sclk});
        lr_sync_d   = SYNC_STAGES'({lr_sync_q, codec_lrclk});
        sdin_sync_d = SYNC_STAGES'({sdin_sync_q, codec_sdin});
        sclk_prev_d = sclk_s;
    end

    always_ff @(posedge clk) begin
        sclk_sync_q <= sclk_sync_d;
        lr_sync_q   <= lr_sync_d;
        sdin_sync_q <= sdin_sync_d;
        sclk_prev_q <= sclk_prev_d;
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s    = lr_sync_q[SYNC_STAGES-1];
    assign sdin_s  = sdin_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;
    // A word boundary needs a known previous lrclk, hence the WAIT state.
    assign start   = rise && (lr_s != lr_prev_q) && (state_q != S_WAIT);
    assign k_inc   = (k_q == K_SAT) ? k_q : k_q + 1'b1;
    assign rx_word = {rx_sh_q[WIDTH-2:0], sdin_s};

`ifdef LOOPBACK_EN
    logic [WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic unused_tx;
    assign unused_tx = ^{tx_vld, tx_data0, tx_data1};
    assign tx_src    = lr_s ? hold1_q : hold0_q;
    assign tx_ok     = 1'b1;

    always_comb begin
        hold0_d = (rx_vld_d && !lr_s) ? rx_word : hold0_q;
        hold1_d = (rx_vld_d && lr_s) ? rx_word : hold1_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
        end
    end
`else
    assign tx_src = tx_vld ? (lr_s ? tx_data1 : tx_data0) : '0;
    assign tx_ok  = tx_vld;
`endif

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        k_d       = k_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        sdout_d   = sdout_q;
        rx_data_d = rx_data_q;
        rx_chan_d = rx_chan_q;
        tx_chan_d = tx_chan_q;
        rx_vld_d  = 1'b0;
        rx_err_d  = 1'b0;
        tx_ack_d  = 1'b0;
        tx_unf_d  = 1'b0;
        if (rise) begin
            lr_prev_d = lr_s;
            if (state_q == S_WAIT) begin
                state_d = S_IDLE;
            end else if (start) begin
                // Delay slot of the new word: sdin ignored, tx word latched.
                state_d   = S_RUN;
                k_d       = '0;
                rx_err_d  = (state_q == S_RUN) && (k_q != '0) && (k_q < K_LAST);
                tx_sh_d   = tx_src;
                tx_ack_d  = tx_ok;
                tx_unf_d  = !tx_ok;
                tx_chan_d = tx_ok ? lr_s : tx_chan_q;
            end else if (state_q == S_RUN) begin
                k_d = k_inc;
                if (k_q < K_LAST) begin
                    rx_sh_d = rx_word;
                    if (k_inc == K_LAST) begin
                        rx_vld_d  = 1'b1;
                        rx_chan_d = lr_s;
                        rx_data_d = rx_word;
                    end
                end
            end
        end
        if (fall) begin
            sdout_d = (state_q == S_RUN) && (k_q < K_LAST) && tx_sh_q[WIDTH-1];
            if ((state_q == S_RUN) && (k_q < K_LAST)) tx_sh_d = tx_sh_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_WAIT;
            lr_prev_q <= 1'b0;
            k_q       <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= '0;
            sdout_q   <= 1'b0;
            rx_data_q <= '0;
            rx_chan_q <= 1'b0;
            tx_chan_q <= 1'b0;
            rx_vld_q  <= 1'b0;
            rx_err_q  <= 1'b0;
            tx_ack_q  <= 1'b0;
            tx_unf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            k_q       <= k_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            sdout_q   <= sdout_d;
            rx_data_q <= rx_data_d;
            rx_chan_q <= rx_chan_d;
            tx_chan_q <= tx_chan_d;
            rx_vld_q  <= rx_vld_d;
            rx_err_q  <= rx_err_d;
            tx_ack_q  <= tx_ack_d;
            tx_unf_q  <= tx_unf_d;
        end
    end

    assign codec_sdout = sdout_q;
    assign rx_vld      = rx_vld_q;
    assign rx_chan     = rx_chan_q;
    assign rx_data     = rx_data_q;
    assign rx_err      = rx_err_q;
    assign tx_ack      = tx_ack_q;
    assign tx_chan     = tx_chan_q;
    assign tx_unf      = tx_unf_q;
endmodule

// File: tb/tb_i2s_codec_slave.sv
// tb_i2s_codec_slave: directed I2S master driving i2s_codec_slave and checking rx/tx words.
`timescale 1ns/1ps
module tb_i2s_codec_slave;
    localparam int W = 24;
`ifdef LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic clk = 1'b0, rstn = 1'b0;
    logic codec_lrclk = 1'b0, codec_sclk = 1'b1, codec_sdin = 1'b0, tx_vld = 1'b0;
    logic [W-1:0] tx_data0 = '0, tx_data1 = '0;
    logic codec_sdout, rx_vld, rx_chan, rx_err, tx_ack, tx_chan, tx_unf;
    logic [W-1:0] rx_data;

    int checks = 0, errors = 0;
    int n_rx = 0, n_err = 0, n_ack = 0, n_unf = 0;
    int e_rx = 0, e_err = 0, e_ack = 0, e_unf = 0;
    logic [W:0] last_rx = '0;
    logic last_ack_ch = 1'b0;
    logic [W-1:0] h0 = '0, h1 = '0, cap = '0;
    int tail = 0;

    i2s_codec_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn),
        .codec_lrclk(codec_lrclk), .codec_sclk(codec_sclk),
        .codec_sdin(codec_sdin), .codec_sdout(codec_sdout),
        .rx_vld(rx_vld), .rx_chan(rx_chan), .rx_data(rx_data), .rx_err(rx_err),
        .tx_vld(tx_vld), .tx_data0(tx_data0), .tx_data1(tx_data1),
        .tx_ack(tx_ack), .tx_chan(tx_chan), .tx_unf(tx_unf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_vld) begin
            n_rx++;
            last_rx = {rx_chan, rx_data};
        end
        if (rx_err) n_err++;
        if (tx_ack) begin
            n_ack++;
            last_ack_ch = tx_chan;
        end
        if (tx_unf) n_unf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master: lrclk/sdin change on sclk fall, sdout sampled on sclk rise.
    task automatic frame(input logic lr, input logic [W-1:0] word, input int nbits);
        cap  = '0;
        tail = 0;
        for (int i = 0; i < nbits; i++) begin
            codec_sclk  = 1'b0;
            codec_lrclk = lr;
            codec_sdin  = (i >= 1 && i <= W) ? word[W-i] : 1'b1;
            #40;
            codec_sclk = 1'b1;
            if (i >= 1 && i <= W) cap[W-i] = codec_sdout;
            else if (i > W && codec_sdout !== 1'b0) tail++;
            #40;
        end
    endtask

    task automatic latch_model();
        if (LB || tx_vld) e_ack++;
        else e_unf++;
    endtask

    task automatic full(input logic lr, input logic [W-1:0] word, input string tag);
        logic [W-1:0] e;
        e = LB ? (lr ? h1 : h0) : (tx_vld ? (lr ? tx_data1 : tx_data0) : '0);
        latch_model();
        e_rx++;
        frame(lr, word, 32);
        chk({tag, "_rx_cnt"}, n_rx, e_rx);
        chk({tag, "_rx_word"}, {7'd0, last_rx}, {7'd0, lr, word});
        chk({tag, "_sdout"}, {8'd0, cap}, {8'd0, e});
        chk({tag, "_tail"}, tail, 0);
        chk({tag, "_ack_cnt"}, n_ack, e_ack);
        chk({tag, "_unf_cnt"}, n_unf, e_unf);
        if (LB || tx_vld) chk({tag, "_ack_ch"}, {31'd0, last_ack_ch}, {31'd0, lr});
        if (lr) h1 = word;
        else h0 = word;
    endtask

    initial begin
        frame(1'b0, '1, 4);
        frame(1'b1, '1, 4);
        chk("rst_sdout", {31'd0, codec_sdout}, 0);
        chk("rst_cap", {8'd0, cap}, 0);
        chk("rst_pulses", n_rx + n_err + n_ack + n_unf, 0);
        chk("rst_rx_data", {8'd0, rx_data}, 0);
        chk("rst_chans", {30'd0, rx_chan, tx_chan}, 0);

        rstn     = 1'b1;
        tx_vld   = 1'b1;
        tx_data0 = 24'h800001;
        tx_data1 = 24'h7FFFFE;
        frame(1'b1, '1, 12);
        chk("idle_pulses", n_rx + n_err + n_ack + n_unf, 0);
        chk("idle_sdout", {8'd0, cap}, 0);

        full(1'b0, 24'hA5C3F0, "ch0");
        full(1'b1, 24'h0F1E2D, "ch1");

        tx_vld = 1'b0;
        full(1'b0, 24'h3C3C3C, "unf");

        tx_vld = 1'b1;
        latch_model();
        frame(1'b1, '1, 11);
        e_err++;
        full(1'b0, 24'h5A5A5A, "short");
        chk("short_err", n_err, e_err);

        latch_model();
        frame(1'b1, '1, 15);
        rstn = 1'b0;
        #80;
        chk("mid_rst_sdout", {31'd0, codec_sdout}, 0);
        chk("mid_rst_rx_cnt", n_rx, e_rx);
        chk("mid_rst_rx_data", {8'd0, rx_data}, 0);
        rstn = 1'b1;
        h0   = '0;
        h1   = '0;
        frame(1'b1, '1, 20);
        chk("post_rst_idle_ack", n_ack, e_ack);
        full(1'b0, 24'h00FF00, "post_rst");
        chk("final_err", n_err, e_err);

        #200;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
